plot_arbiter: RTL

Shares the single VGA framebuffer write port between the pixel-stream producers: screen clear, brick display, ball, paddle. Each requester streams pixels under a valid/ack handshake. The arbiter grants one requester at a time in round-robin order and holds the grant until that requester's last pixel. Accepted pixels are registered onto the VGA plot bus. It sits between the sprite drawers and the VGA adapter, beside the sprite sequencing FSM.

---
 rtl/plot_arb_pkg.sv | 31 +++
 rtl/plot_arbiter_rr_picker.sv | 40 ++++
 rtl/plot_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/plot_arb_pkg.sv
// ---------------------------------------------------------------------------
// plot_arb_pkg
// Shared types and constants for the VGA plot-port arbiter.
//   arb_state_t    : arbiter FSM state (IDLE, STREAM)
//   REQ_*          : requester index assignments
//   DEF_*          : default bus widths and burst length
//   idx_width()    : width of a requester index, never below one bit
// ---------------------------------------------------------------------------
package plot_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } arb_state_t;

    localparam int REQ_CLEAR  = 0;
    localparam int REQ_BRICK  = 1;
    localparam int REQ_BALL   = 2;
    localparam int REQ_PADDLE = 3;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_X_W       = 8;
    localparam int DEF_Y_W       = 7;
    localparam int DEF_C_W       = 3;
    localparam int DEF_MAX_BURST = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plot_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational rotate-priority encoder. Searches the request vector starting
// one position after the previous owner and wrapping, so the previous owner
// is considered last.
//   req        in  NUM_REQ  request vector
//   last_owner in  IDX_W    index of the previous grant holder
//   winner     out IDX_W    selected requester (0 when none)
//   any        out 1        at least one request is set
// ---------------------------------------------------------------------------
module rr_picker
    import plot_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    int unsigned idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves a value held (no latch).
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// ---------------------------------------------------------------------------
// plot_arbiter
// Shares the single VGA framebuffer write port between pixel-stream
// producers (clear, brick, ball, paddle). One requester owns the port at a
// time, chosen round-robin, and keeps it until its last pixel. Accepted
// pixels are registered onto the VGA plot bus one cycle after the ack.
//
// Optional feature macro: PLOT_ARB_BURST_LIMIT_EN
//   When defined, a grant is also released after MAX_BURST accepted pixels
//   so a long stream (the screen clear) cannot starve the sprites.
//
// Ports
//   clock        in  1             system clock, rising edge
//   reset        in  1             asynchronous, active-high reset
//   req_valid    in  NUM_REQ       requester i presents a pixel
//   req_last     in  NUM_REQ       presented pixel ends requester i's sprite
//   req_x        in  NUM_REQ*X_W   flattened x, requester i at [i*X_W +: X_W]
//   req_y        in  NUM_REQ*Y_W   flattened y
//   req_colour   in  NUM_REQ*C_W   flattened colour
//   req_ack      out NUM_REQ       one-hot pixel accept, combinational
//   plot         out 1             VGA write enable, registered
//   plot_x       out X_W           registered pixel x
//   plot_y       out Y_W           registered pixel y
//   plot_colour  out C_W           registered pixel colour
//   grant_id     out IDX_W         current owner, registered
//   busy         out 1             high while streaming
// ---------------------------------------------------------------------------
module plot_arbiter
    import plot_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int C_W       = DEF_C_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDX_W     = idx_width(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   plot,
    output logic [X_W-1:0]         plot_x,
    output logic [Y_W-1:0]         plot_y,
    output logic [C_W-1:0]         plot_colour,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy
);

    arb_state_t       state;
    arb_state_t       next_state;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] winner;
    logic             any_req;

    logic             owner_valid;
    logic             owner_last;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_colour;
    logic             accept;
    logic             release_grant;
    logic             burst_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_owner (last_owner),
        .winner     (winner),
        .any        (any_req)
    );

    // Owner's lane of the flattened request buses.
    always_comb begin
        owner_valid = req_valid[grant_id];
        owner_last  = req_last[grant_id];
        sel_x       = req_x[int'(grant_id)*X_W +: X_W];
        sel_y       = req_y[int'(grant_id)*Y_W +: Y_W];
        sel_colour  = req_colour[int'(grant_id)*C_W +: C_W];
    end

`ifdef PLOT_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] burst_cnt;

    // True when the pixel accepted this cycle is the MAX_BURST-th of the grant.
    assign burst_hit = (burst_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            burst_cnt <= '0;
        end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end
`else
    assign burst_hit = 1'b0;
`endif

    always_comb begin
        next_state    = state;
        req_ack       = '0;
        accept        = 1'b0;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                accept            = owner_valid;
                req_ack[grant_id] = owner_valid;
                if (owner_valid && (owner_last || burst_hit)) begin
                    release_grant = 1'b1;
                    next_state    = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and are all cleared
    // by the asynchronous reset, so a reset aborts a burst immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            grant_id    <= '0;
            plot        <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
        end else begin
            state <= next_state;
            plot  <= accept;
            if (state == IDLE && any_req) begin
                grant_id <= winner;
            end
            if (release_grant) begin
                last_owner <= grant_id;
            end
            if (accept) begin
                plot_x      <= sel_x;
                plot_y      <= sel_y;
                plot_colour <= sel_colour;
            end
        end
    end

    assign busy = (state == STREAM);

endmodule
